// File: rtl/serial_parallel_multiplier_pkg.sv
// Shared definitions for the serial-parallel shift-add multiplier.
//   state_t   : control FSM states (IDLE, BUSY, DONE)
//   cnt_width : bit-counter width for a given operand width, $clog2(w+1),
//               wide enough to hold the terminal count w itself
package serial_parallel_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CNT_W = $clog2(DEF_WIDTH + 1);

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_parallel_multiplier_shift_add_datapath.sv
// Shift-add datapath: accumulator, multiplier shift register and the
// WIDTH+1-bit adder.
//   clk, rst : clock, synchronous active-high reset (clears all registers)
//   load     : latch mp/mc, clear the accumulator
//   step     : consume one multiplier bit (LSB first)
//   mp, mc   : multiplier (serial side), multiplicand (parallel side)
//   acc      : 2*WIDTH accumulator; holds the product after WIDTH steps
module shift_add_datapath
    import serial_parallel_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mp,
    input  logic [WIDTH-1:0]     mc,
    output logic [2*WIDTH-1:0]   acc
);

    logic [WIDTH-1:0] mp_r;
    logic [WIDTH-1:0] mc_r;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;

    // Carry out of the upper-half add is kept and shifted into the MSB.
    always_comb begin
        addend = mp_r[0] ? mc_r : '0;
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            mp_r <= '0;
            mc_r <= '0;
        end else if (load) begin
            acc  <= '0;
            mp_r <= mp;
            mc_r <= mc;
        end else if (step) begin
            acc  <= {sum, acc[WIDTH-1:1]};
            mp_r <= {1'b0, mp_r[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_parallel_multiplier.sv
// Unsigned WIDTH x WIDTH serial-parallel multiplier with start/done handshake.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, priority over start
//   MP    : multiplier operand, consumed one bit per clock LSB first
//   MC    : multiplicand operand, applied in parallel
//   start : level-sampled request; accepted in IDLE or DONE
//   P     : registered 2*WIDTH product, held until the next result completes
//   done  : high while P holds a completed result
// Latency: start accepted at edge N -> done/P valid after edge N+WIDTH+1.
module serial_parallel_multiplier
    import serial_parallel_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     MP,
    input  logic [WIDTH-1:0]     MC,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   P,
    output logic                 done
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t              state, state_n;
    logic   [CW-1:0]     cnt;
    logic                load, step, finish;
    logic   [2*WIDTH-1:0] acc;

    shift_add_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .mp   (MP),
        .mc   (MC),
        .acc  (acc)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // BUSY spends WIDTH edges stepping, then one more edge to publish P.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (cnt == CW'(WIDTH)) begin
                    finish  = 1'b1;
                    state_n = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)       cnt <= '0;
        else if (load) cnt <= '0;
        else if (step) cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            P    <= '0;
            done <= 1'b0;
        end else if (load) begin
            done <= 1'b0;
        end else if (finish) begin
            P    <= acc;
            done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_parallel_multiplier.sv
// Self-checking bench for serial_parallel_multiplier (WIDTH=32).
// Expected products come from plain 64-bit multiplication; expected latency
// is WIDTH+1 edges after the accepting edge.
module tb_serial_parallel_multiplier;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [W-1:0]    MP, MC;
    logic            start;
    logic [2*W-1:0]  P;
    logic            done;

    int n_cmp = 0;
    int n_err = 0;
    logic [2*W-1:0] last_p;

    serial_parallel_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .MP    (MP),
        .MC    (MC),
        .start (start),
        .P     (P),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits for done after an accepting edge. Start stays high while k < hold;
    // with disturb, operands and start are scrambled early in the operation.
    task automatic wait_done(input int hold, input bit disturb, output int k);
        k = 0;
        while (k < 40) begin
            k++;
            start = (k < hold);
            if (disturb && k >= 2 && k <= 8) begin
                MP    = $urandom;
                MC    = $urandom;
                start = k[0];
            end
            tick();
            if (k == 5) check_eq("p_held_busy", P, last_p);
            if (done) break;
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input bit disturb, input string tag);
        logic [2*W-1:0] exp;
        int k;
        exp   = 64'(a) * 64'(b);
        MP    = a;
        MC    = b;
        start = 1'b1;
        tick();
        check_eq({tag, "_done_low"}, 64'(done), 64'd0);
        wait_done(hold, disturb, k);
        check_eq({tag, "_lat"}, 64'(k), 64'(LAT));
        check_eq({tag, "_P"}, P, exp);
        last_p = exp;
    endtask

    initial begin
        logic [W-1:0] a, b;
        int k;
        rst = 1'b1; start = 1'b1; MP = 32'd9; MC = 32'd9;
        tick();
        rst = 1'b0; start = 1'b0;
        check_eq("rst_P", P, 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        last_p = '0;

        // start held for 4 cycles
        do_op(32'd15, 32'd7, 4, 1'b0, "t15x7");
        repeat (3) begin
            tick();
            check_eq("stable_done", 64'(done), 64'd1);
            check_eq("stable_P", P, 64'd105);
        end

        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0, "ones");
        check_eq("ones_const", P, 64'hFFFF_FFFE_0000_0001);
        do_op(32'd0, 32'h1234_5678, 1, 1'b0, "mp0");
        do_op(32'd1, 32'h89AB_CDEF, 1, 1'b0, "mp1");
        check_eq("mp1_const", P, 64'h0000_0000_89AB_CDEF);

        // operand changes and start pulses during BUSY
        do_op(32'd3, 32'd5, 1, 1'b1, "ignore");
        check_eq("ignore_const", P, 64'd15);

        // reset at cycle 10 of an operation
        MP = 32'd1000; MC = 32'd1000; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_P", P, 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        repeat (40) tick();
        check_eq("abort_idle_done", 64'(done), 64'd0);
        check_eq("abort_idle_P", P, 64'd0);
        last_p = '0;
        do_op(32'd6, 32'd7, 1, 1'b0, "after_rst");

        // back-to-back: start held across completion
        do_op(32'd1234, 32'd5678, 1000, 1'b0, "b2b_first");
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
        MP = a; MC = b; start = 1'b1;
        tick();
        check_eq("b2b_done_1cyc", 64'(done), 64'd0);
        check_eq("b2b_P_held", P, 64'd1234 * 64'd5678);
        wait_done(1, 1'b0, k);
        check_eq("b2b_lat", 64'(k), 64'(LAT));
        check_eq("b2b_P", P, 64'(a) * 64'(b));
        last_p = P;

        // randomized sweep
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 5))
                0:       a = '0;
                1:       a = '1;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = '1;
                default: b = $urandom;
            endcase
            do_op(a, b, 1, 1'(i % 7 == 3), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
